// File: rtl/stream_demux_1to2_if.sv
// Handshake bundle for the 1-to-2 packet demux:
// one input stream, two output streams, two packet counters.
interface stream_demux_1to2_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;

  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;

  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;

  logic [7:0]       pkt_cnt0;
  logic [7:0]       pkt_cnt1;

  modport master (
    output in_valid, in_data, in_sel, in_last,
    output out0_ready, out1_ready,
    input  in_ready,
    input  out0_valid, out0_data, out0_last,
    input  out1_valid, out1_data, out1_last,
    input  pkt_cnt0, pkt_cnt1
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_last,
    input  out0_ready, out1_ready,
    output in_ready,
    output out0_valid, out0_data, out0_last,
    output out1_valid, out1_data, out1_last,
    output pkt_cnt0, pkt_cnt1
  );
endinterface

// File: rtl/stream_demux_1to2.sv
// Packet-level 1-to-2 stream demux with a route lock
// per packet and a FWFT buffer on each output channel.
module stream_demux_1to2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_demux_1to2_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  state_t state_nxt;
  logic   lock_sel;
  logic   lock_sel_nxt;
  logic   target;
  logic   accept;

  logic [1:0]            full;
  logic [1:0]            vld;
  logic [1:0]            lst;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0][WIDTH-1:0] dat;
  logic [1:0][7:0]       pkt;

  assign accept = bus.in_valid & bus.in_ready;

  assign push[0] = accept & ~target;
  assign push[1] = accept &  target;
  assign pop[0]  = vld[0] & bus.out0_ready;
  assign pop[1]  = vld[1] & bus.out1_ready;

  // Route state and packet lock register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  // First beat locks the route; last beat releases it
  always_comb begin
    state_nxt    = state;
    lock_sel_nxt = lock_sel;
    unique case (state)
      IDLE: begin
        if (accept && !bus.in_last) begin
          state_nxt    = BUSY;
          lock_sel_nxt = bus.in_sel;
        end
      end
      BUSY: begin
        if (accept && bus.in_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Target channel and input backpressure from its fill level
  always_comb begin
    target = lock_sel;
    if (state == IDLE) begin
      target = bus.in_sel;
    end
    bus.in_ready = !rst && !full[target];
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [7:0]      cnt;

    // FWFT buffer: pointers wrap on power-of-two depth
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        if (push[c]) begin
          mem[wr_ptr] <= {bus.in_last, bus.in_data};
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop[c]) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        unique case ({push[c], pop[c]})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end

    // Count packets whose last beat leaves the buffer
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= 8'd0;
      end else if (pop[c] && lst[c]) begin
        cnt <= cnt + 8'd1;
      end
    end

    assign full[c] = (count == (AW+1)'(DEPTH));
    assign vld[c]  = (count != '0);
    assign {lst[c], dat[c]} = mem[rd_ptr];
    assign pkt[c]  = cnt;
  end

  assign bus.out0_valid = vld[0];
  assign bus.out0_data  = dat[0];
  assign bus.out0_last  = lst[0];
  assign bus.out1_valid = vld[1];
  assign bus.out1_data  = dat[1];
  assign bus.out1_last  = lst[1];
  assign bus.pkt_cnt0   = pkt[0];
  assign bus.pkt_cnt1   = pkt[1];
endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2 (WIDTH 8, DEPTH 2).
// Inputs change at negedge; checks run 1 time unit later.
module tb_stream_demux_1to2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  stream_demux_1to2_if #(.WIDTH(8)) bus ();

  stream_demux_1to2 #(.WIDTH(8), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic s, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_last  = l;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("rst_in_ready", 32'(bus.in_ready), 0);
    end
    chk("rst_v0", 32'(bus.out0_valid), 0);
    chk("rst_v1", 32'(bus.out1_valid), 0);
    chk("rst_d0", 32'(bus.out0_data), 0);
    chk("rst_d1", 32'(bus.out1_data), 0);
    chk("rst_c0", 32'(bus.pkt_cnt0), 0);
    chk("rst_c1", 32'(bus.pkt_cnt1), 0);
    nxt(); rst = 1'b0; #1;
    chk("rel_in_ready", 32'(bus.in_ready), 1);

    // packet lock: sel changes after first beat are ignored
    drive(1'b1, 8'h11, 1'b1, 1'b0); #1;
    chk("lk_rdy", 32'(bus.in_ready), 1);
    nxt(); drive(1'b1, 8'h22, 1'b0, 1'b0); #1;
    chk("lk_d1", 32'(bus.out1_data), 32'h11);
    chk("lk_l1", 32'(bus.out1_last), 0);
    chk("lk_v0a", 32'(bus.out0_valid), 0);
    nxt(); drive(1'b1, 8'h33, 1'b0, 1'b1); #1;
    chk("lk_d2", 32'(bus.out1_data), 32'h22);
    chk("lk_v0b", 32'(bus.out0_valid), 0);
    nxt(); drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("lk_d3", 32'(bus.out1_data), 32'h33);
    chk("lk_l3", 32'(bus.out1_last), 1);
    chk("lk_v0c", 32'(bus.out0_valid), 0);
    nxt(); #1;
    chk("lk_v1e", 32'(bus.out1_valid), 0);
    chk("lk_c1", 32'(bus.pkt_cnt1), 1);
    chk("lk_c0", 32'(bus.pkt_cnt0), 0);

    // single-beat alternation
    drive(1'b1, 8'hA0, 1'b0, 1'b1);
    nxt(); drive(1'b1, 8'hB0, 1'b1, 1'b1); #1;
    chk("alt_v0", 32'(bus.out0_valid), 1);
    chk("alt_d0", 32'(bus.out0_data), 32'hA0);
    chk("alt_rdy", 32'(bus.in_ready), 1);
    nxt(); drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("alt_v1", 32'(bus.out1_valid), 1);
    chk("alt_d1", 32'(bus.out1_data), 32'hB0);
    chk("alt_v0e", 32'(bus.out0_valid), 0);
    nxt(); #1;
    chk("alt_c0", 32'(bus.pkt_cnt0), 1);
    chk("alt_c1", 32'(bus.pkt_cnt1), 2);

    // full buffer and backpressure on channel 0
    bus.out0_ready = 1'b0;
    drive(1'b1, 8'hC1, 1'b0, 1'b0); #1;
    chk("full_r0", 32'(bus.in_ready), 1);
    nxt(); drive(1'b1, 8'hC2, 1'b1, 1'b0); #1;
    chk("full_r1", 32'(bus.in_ready), 1);
    nxt(); drive(1'b1, 8'hC3, 1'b1, 1'b1); #1;
    chk("full_r2", 32'(bus.in_ready), 0);
    chk("full_hd", 32'(bus.out0_data), 32'hC1);
    nxt(); bus.out0_ready = 1'b1; #1;
    chk("full_popblk", 32'(bus.in_ready), 0);
    nxt(); #1;
    chk("full_reopen", 32'(bus.in_ready), 1);
    chk("full_d2", 32'(bus.out0_data), 32'hC2);
    chk("full_v1", 32'(bus.out1_valid), 0);
    nxt(); drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("full_d3", 32'(bus.out0_data), 32'hC3);
    chk("full_l3", 32'(bus.out0_last), 1);
    nxt(); #1;
    chk("full_v0e", 32'(bus.out0_valid), 0);
    chk("full_c0", 32'(bus.pkt_cnt0), 2);

    // channel independence: ch0 stalled full, ch1 flows
    bus.out0_ready = 1'b0;
    drive(1'b1, 8'hD1, 1'b0, 1'b1);
    nxt(); drive(1'b1, 8'hD2, 1'b0, 1'b1);
    nxt(); #1;
    chk("ind_blk0", 32'(bus.in_ready), 0);
    drive(1'b1, 8'hE1, 1'b1, 1'b1); #1;
    chk("ind_rdy1", 32'(bus.in_ready), 1);
    nxt(); drive(1'b1, 8'hE2, 1'b1, 1'b1); #1;
    chk("ind_e1", 32'(bus.out1_data), 32'hE1);
    chk("ind_r2", 32'(bus.in_ready), 1);
    nxt(); drive(1'b1, 8'hE3, 1'b1, 1'b1); #1;
    chk("ind_e2", 32'(bus.out1_data), 32'hE2);
    chk("ind_r3", 32'(bus.in_ready), 1);
    nxt(); drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("ind_e3", 32'(bus.out1_data), 32'hE3);
    nxt(); #1;
    chk("ind_c1", 32'(bus.pkt_cnt1), 5);
    chk("ind_d0", 32'(bus.out0_data), 32'hD1);
    chk("ind_v0", 32'(bus.out0_valid), 1);
    bus.out0_ready = 1'b1;
    nxt(); #1;
    chk("ind_d0b", 32'(bus.out0_data), 32'hD2);
    nxt(); #1;
    chk("ind_c0", 32'(bus.pkt_cnt0), 4);
    chk("ind_v0e", 32'(bus.out0_valid), 0);

    // reset mid-packet on channel 1
    bus.out1_ready = 1'b0;
    drive(1'b1, 8'hF1, 1'b1, 1'b0);
    nxt(); drive(1'b1, 8'hF2, 1'b0, 1'b0);
    nxt(); #1;
    chk("mid_v1", 32'(bus.out1_valid), 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    nxt(); rst = 1'b0; #1;
    chk("mid_v1e", 32'(bus.out1_valid), 0);
    chk("mid_v0e", 32'(bus.out0_valid), 0);
    chk("mid_c1", 32'(bus.pkt_cnt1), 0);
    bus.out1_ready = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b1); #1;
    chk("mid_rdy", 32'(bus.in_ready), 1);
    nxt(); drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("mid_v0", 32'(bus.out0_valid), 1);
    chk("mid_d0", 32'(bus.out0_data), 32'h5A);
    chk("mid_v1b", 32'(bus.out1_valid), 0);
    nxt(); #1;
    chk("mid_c0", 32'(bus.pkt_cnt0), 1);

    // counter wrap: 256 single-beat packets after a reset
    rst = 1'b1;
    nxt(); rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1); #1;
      if (bus.in_ready !== 1'b1) begin
        chk("wrap_rdy", 32'(bus.in_ready), 1);
      end
      nxt();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0); #1;
    chk("wrap_255", 32'(bus.pkt_cnt0), 32'hFF);
    chk("wrap_hd", 32'(bus.out0_data), 32'hFF);
    nxt(); #1;
    chk("wrap_0", 32'(bus.pkt_cnt0), 0);
    chk("wrap_v0e", 32'(bus.out0_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_demux_1to2.md
# stream_demux_1to2

Packet-level 1-to-2 stream demultiplexer with valid/ready handshakes and a DEPTH-entry first-word-fall-through buffer per output channel. A select bit sampled on the first beat of a packet locks the route until that packet's last beat. The block sits downstream of the combinational 1-to-2 demux select logic: it turns the single-cycle steer into a buffered, backpressure-aware two-channel packet router. Per-channel packet counters support debug and verification.

## Interface
- WIDTH, 8, data beat width in bits
- DEPTH, 2, entries per output buffer; power of two, ≥2
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept the beat
- in_data  input  WIDTH  beat payload
- in_sel  input  1  route for the packet, sampled only on the packet's first beat: 0 selects out0, 1 selects out1
- in_last  input  1  final beat of the packet
- out0_valid / out1_valid  output  1  buffer non-empty
- out0_ready / out1_ready  input  1  downstream accepts the beat
- out0_data / out1_data  output  WIDTH  head-of-buffer payload
- out0_last / out1_last  output  1  head-of-buffer last flag
- pkt_cnt0 / pkt_cnt1  output  8  packets fully delivered per channel; wraps 255→0

## Operation
- Transfers: input accept = in_valid & in_ready. Output pop = outN_valid & outN_ready.
- FSM, 2 states:
  - IDLE: target = in_sel.
  - BUSY: target = lock_sel. in_sel is ignored.
- FSM transitions:
  - IDLE, accept with in_last=0: latch lock_sel = in_sel, go to BUSY.
  - IDLE, accept with in_last=1: stay IDLE (single-beat packet).
  - BUSY, accept with in_last=1: go to IDLE.
  - No accept: hold state.
- in_ready = !rst & !full(target). It has no combinational dependence on outN_ready.
  - A full buffer that is popping in the same cycle still refuses the push. There is no bypass.
- Each accepted beat pushes {in_last, in_data} into the target buffer only. The other buffer is untouched.
- Buffers: FWFT circular storage with read/write pointers and an occupancy count of 0..DEPTH.
  - outN_valid = count≠0.
  - outN_data and outN_last show the head entry.
  - Pointers wrap DEPTH-1→0.
  - Simultaneous push and pop on a non-full, non-empty buffer leaves the count unchanged.
  - Push and pop on the same cycle with count=0 is impossible: valid is low, so there is no pop.
- The two channels are fully independent. Backpressure on one never stalls the other, except while the input is targeting the stalled channel.
- pkt_cntN increments on each pop with outN_last=1.
- Reset values:
  - State IDLE, lock_sel 0, all pointers and counts 0, storage cleared to 0.
  - outN_valid 0, outN_data 0, outN_last 0, pkt_cntN 0.
  - in_ready 0 while rst=1, and 1 on the first cycle after rst deasserts.
- Reset mid-packet discards all buffered beats and the lock. The next accepted beat is treated as a packet's first beat.

## Timing
- Latency: a beat accepted at edge N is visible at outN_valid/data after edge N, i.e. 1 cycle. No combinational input→output data path.
- Throughput: 1 beat/cycle per channel when the downstream is always ready. in_ready drops only when the target buffer holds DEPTH entries.
- in_ready settles combinationally from registered state and in_sel (IDLE only).
- The FSM state change takes effect the cycle after the accepting edge.
- A packet ending on edge N lets the next packet, with either in_sel, be accepted at edge N+1.
- pkt_cntN updates at the edge of the last-beat pop and is visible the following cycle.

## Test plan
- Reset/idle:
  - Stimulus: hold rst 3 cycles, then release.
  - Required response: in_ready=0 during reset; all valids, data and counters 0; in_ready=1 the cycle after release.
- Packet lock:
  - Stimulus: 3-beat packet 0x11,0x22,0x33 with in_sel=1, 0, 0 per beat; both outputs ready.
  - Required response: all three beats appear on out1 in order with last on 0x33; out0_valid stays 0; pkt_cnt1=1.
- Single-beat alternation:
  - Stimulus: beats 0xA0 (sel 0, last) then 0xB0 (sel 1, last) on consecutive cycles.
  - Required response: out0 shows 0xA0 and out1 shows 0xB0, each 1 cycle after acceptance; both counters 1.
- Full/backpressure:
  - Stimulus: out0_ready=0; push DEPTH+1 beats to channel 0.
  - Required response: in_ready falls after DEPTH accepts. With out0_ready=1 asserted while full, in_ready stays 0 that cycle, then 1 the next. Data order is preserved.
- Channel independence:
  - Stimulus: out0 stalled and full; IDLE with in_sel=1.
  - Required response: in_ready=1 and channel 1 flows at 1 beat/cycle.
- Reset mid-packet:
  - Stimulus: assert rst after beat 2 of a 4-beat packet on channel 1.
  - Required response: buffers empty, state IDLE. Next beat with in_sel=0 goes to out0.
- Counter wrap:
  - Stimulus: 256 single-beat packets to channel 0.
  - Required response: pkt_cnt0 returns to 0.
